// File: rtl/st_fifo_ml.sv
// st_fifo_ml: multi-entry elastic buffer for an axis-like stream (valid/last/user/data/ready).
//
// Modes:
//   PKT_MODE = 0  cut-through: any stored beat is presented to the output.
//   PKT_MODE = 1  store-and-forward: beats are held until a complete packet is stored.
//                 If the FIFO fills without any complete packet, the head packet is
//                 released early and streams cut-through until its last beat leaves.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   axis_*              upstream beat (tvalid/tlast/tuser/tdata in, tready out)
//   axis_reg_*          downstream beat (tvalid/tlast/tuser/tdata out, tready in)
//   axis_reg_sop        current output beat is the first beat of a packet
//   fifo_count          number of stored entries
//   pkt_count           number of stored entries carrying tlast
module st_fifo_ml #(
    parameter int unsigned TUSER_WIDTH = 128,
    parameter int unsigned TDATA_WIDTH = 256,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned PKT_MODE    = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       axis_tvalid,
    input  logic                       axis_tlast,
    input  logic [TUSER_WIDTH-1:0]     axis_tuser,
    input  logic [TDATA_WIDTH-1:0]     axis_tdata,
    output logic                       axis_tready,
    output logic                       axis_reg_tvalid,
    output logic                       axis_reg_tlast,
    output logic [TUSER_WIDTH-1:0]     axis_reg_tuser,
    output logic [TDATA_WIDTH-1:0]     axis_reg_tdata,
    input  logic                       axis_reg_tready,
    output logic                       axis_reg_sop,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic [$clog2(DEPTH):0]     pkt_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    // Entry layout: {tlast, tuser, tdata}
    localparam int unsigned EW = 1 + TUSER_WIDTH + TDATA_WIDTH;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("st_fifo_ml: DEPTH must be a power of two and at least 2");
    end

    logic [EW-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] pkt_q, pkt_d;
    logic          sop_q, sop_d;
    logic          esc_q, esc_d;

    logic          push, pop;
    logic          full, not_empty, release_ok;
    logic          push_last, pop_last;
    logic [EW-1:0] head;
    logic          head_last;

    always_comb begin
        head      = mem_q[rd_ptr_q];
        head_last = head[EW-1];
        full      = (count_q == FULL_CNT);
        not_empty = (count_q != '0);

        // Packet-mode gate: a complete packet is stored, the FIFO is full (deadlock
        // escape), or an escaped packet is still streaming out.
        if (PKT_MODE != 0) begin
            release_ok = (pkt_q != '0) | full | esc_q;
        end else begin
            release_ok = 1'b1;
        end

        axis_tready     = !rst & !full;
        axis_reg_tvalid = !rst & not_empty & release_ok;
        axis_reg_tlast  = axis_reg_tvalid & head_last;
        axis_reg_tuser  = axis_reg_tvalid ? head[TDATA_WIDTH +: TUSER_WIDTH] : '0;
        axis_reg_tdata  = axis_reg_tvalid ? head[TDATA_WIDTH-1:0] : '0;
        axis_reg_sop    = sop_q & axis_reg_tvalid;
        fifo_count      = count_q;
        pkt_count       = pkt_q;

        push      = axis_tvalid & axis_tready;
        pop       = axis_reg_tvalid & axis_reg_tready;
        push_last = push & axis_tlast;
        pop_last  = pop & head_last;

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        pkt_d = pkt_q;
        if (push_last && !pop_last) begin
            pkt_d = pkt_q + CW'(1);
        end else if (pop_last && !push_last) begin
            pkt_d = pkt_q - CW'(1);
        end

        sop_d = pop ? head_last : sop_q;

        // Escape latches when a beat leaves a full FIFO with no complete packet, so
        // valid stays up for the rest of that packet after the FIFO is no longer full.
        esc_d = esc_q;
        if (pop_last) begin
            esc_d = 1'b0;
        end else if (pop && full && pkt_q == '0) begin
            esc_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            pkt_q    <= '0;
            sop_q    <= 1'b1;
            esc_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            pkt_q    <= pkt_d;
            sop_q    <= sop_d;
            esc_q    <= esc_d;
        end
    end

    // Storage is not reset; push is already blocked while rst is high.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {axis_tlast, axis_tuser, axis_tdata};
        end
    end

endmodule

// File: tb/tb_st_fifo_ml.sv
// Directed bench for st_fifo_ml: instance 0 is cut-through, instance 1 is packet mode.
module tb_st_fifo_ml;

    localparam int UW = 8;
    localparam int DW = 16;

    logic          clk;
    logic          rst;
    logic          tvalid     [2];
    logic          tlast      [2];
    logic [UW-1:0] tuser      [2];
    logic [DW-1:0] tdata      [2];
    logic          tready     [2];
    logic          reg_tvalid [2];
    logic          reg_tlast  [2];
    logic [UW-1:0] reg_tuser  [2];
    logic [DW-1:0] reg_tdata  [2];
    logic          reg_tready [2];
    logic          reg_sop    [2];
    logic [2:0]    fcount     [2];
    logic [2:0]    pcount     [2];

    int n_chk = 0;
    int n_bad = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        st_fifo_ml #(
            .TUSER_WIDTH (UW),
            .TDATA_WIDTH (DW),
            .DEPTH       (4),
            .PKT_MODE    (g)
        ) u_dut (
            .clk             (clk),
            .rst             (rst),
            .axis_tvalid     (tvalid[g]),
            .axis_tlast      (tlast[g]),
            .axis_tuser      (tuser[g]),
            .axis_tdata      (tdata[g]),
            .axis_tready     (tready[g]),
            .axis_reg_tvalid (reg_tvalid[g]),
            .axis_reg_tlast  (reg_tlast[g]),
            .axis_reg_tuser  (reg_tuser[g]),
            .axis_reg_tdata  (reg_tdata[g]),
            .axis_reg_tready (reg_tready[g]),
            .axis_reg_sop    (reg_sop[g]),
            .fifo_count      (fcount[g]),
            .pkt_count       (pcount[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int m, input logic v, input logic l, input int d, input logic rr);
        tvalid[m]     = v;
        tlast[m]      = l;
        tdata[m]      = DW'(d);
        tuser[m]      = UW'(d) ^ 8'h5A;
        reg_tready[m] = rr;
    endtask

    task automatic check_beat(input int m, input string tag, input int d, input logic sop,
                              input logic last);
        logic [UW-1:0] exp_user;
        exp_user = UW'(d) ^ 8'h5A;
        check_eq({tag, " valid"}, 32'(reg_tvalid[m]), 32'd1);
        check_eq({tag, " data"}, 32'(reg_tdata[m]), 32'(DW'(d)));
        check_eq({tag, " user"}, 32'(reg_tuser[m]), 32'(exp_user));
        check_eq({tag, " sop"}, 32'(reg_sop[m]), 32'(sop));
        check_eq({tag, " last"}, 32'(reg_tlast[m]), 32'(last));
    endtask

    // Push n beats (base, base+1, ...; tlast on the final one) with the sink always ready.
    // Checks order/sop/last of every output beat and how many beats had been accepted
    // when the first output beat appeared.
    task automatic stream(input int m, input string tag, input int n, input int base,
                          input int exp_first);
        int idx = 0;
        int got = 0;
        int first_at = -1;
        int cyc = 0;
        while (got < n && cyc < 40) begin
            drive(m, idx < n, idx == n - 1, base + idx, 1'b1);
            #1;
            if (reg_tvalid[m]) begin
                if (first_at < 0) first_at = idx;
                check_beat(m, tag, base + got, got == 0, got == n - 1);
                got++;
            end
            if (tvalid[m] && tready[m]) idx++;
            @(negedge clk);
            cyc++;
        end
        drive(m, 1'b0, 1'b0, 0, 1'b0);
        #1;
        check_eq({tag, " delivered"}, 32'(got), 32'(n));
        check_eq({tag, " first_at"}, 32'(first_at), 32'(exp_first));
        check_eq({tag, " count_end"}, 32'(fcount[m]), 32'd0);
        check_eq({tag, " pkt_end"}, 32'(pcount[m]), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        for (int m = 0; m < 2; m++) drive(m, 1'b0, 1'b0, 0, 1'b0);

        // Reset and idle
        @(negedge clk);
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            check_eq("rst tready", 32'(tready[m]), 32'd0);
            check_eq("rst valid", 32'(reg_tvalid[m]), 32'd0);
        end
        rst = 1'b0;
        #1;
        for (int m = 0; m < 2; m++) begin
            check_eq("idle tready", 32'(tready[m]), 32'd1);
            check_eq("idle valid", 32'(reg_tvalid[m]), 32'd0);
            check_eq("idle data", 32'(reg_tdata[m]), 32'd0);
            check_eq("idle user", 32'(reg_tuser[m]), 32'd0);
            check_eq("idle last", 32'(reg_tlast[m]), 32'd0);
            check_eq("idle count", 32'(fcount[m]), 32'd0);
        end
        @(negedge clk);

        // Cut-through: fill with 1..4 under backpressure, then drain
        for (int i = 1; i <= 4; i++) begin
            drive(0, 1'b1, i == 4, i, 1'b0);
            @(negedge clk);
        end
        drive(0, 1'b0, 1'b0, 0, 1'b0);
        #1;
        check_eq("fill tready", 32'(tready[0]), 32'd0);
        check_eq("fill count", 32'(fcount[0]), 32'd4);
        check_eq("fill pkt", 32'(pcount[0]), 32'd1);
        reg_tready[0] = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            check_beat(0, "drain", i, i == 1, i == 4);
            if (i == 2) check_eq("tready after full pop", 32'(tready[0]), 32'd1);
            @(negedge clk);
        end
        #1;
        check_eq("drain valid", 32'(reg_tvalid[0]), 32'd0);
        check_eq("drain count", 32'(fcount[0]), 32'd0);
        check_eq("drain pkt", 32'(pcount[0]), 32'd0);

        // Cut-through: steady push+pop at count 2, pointers wrap
        drive(0, 1'b1, 1'b0, 11, 1'b0);
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 12, 1'b0);
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            drive(0, 1'b1, k == 9, 13 + k, 1'b1);
            #1;
            check_eq("steady count", 32'(fcount[0]), 32'd2);
            check_eq("steady data", 32'(reg_tdata[0]), 32'(11 + k));
            check_eq("steady sop", 32'(reg_sop[0]), 32'(k == 0));
            @(negedge clk);
        end
        for (int k = 0; k < 2; k++) begin
            drive(0, 1'b0, 1'b0, 0, 1'b1);
            #1;
            check_beat(0, "steady tail", 21 + k, 1'b0, k == 1);
            @(negedge clk);
        end
        #1;
        check_eq("steady end count", 32'(fcount[0]), 32'd0);

        // Cut-through latency: first output one cycle after first push
        stream(0, "ct3", 3, 100, 1);
        // Packet mode: held until the 4-beat packet is complete
        stream(1, "pm4", 4, 31, 4);
        // Packet mode: 6-beat packet escapes when full, remainder cut-through
        stream(1, "pm6", 6, 41, 4);

        // Reset mid-packet with the sop flag cleared
        for (int i = 0; i < 3; i++) begin
            drive(0, 1'b1, 1'b0, 51 + i, 1'b0);
            @(negedge clk);
        end
        drive(0, 1'b0, 1'b0, 0, 1'b1);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 0, 1'b0);
        #1;
        check_eq("mid count", 32'(fcount[0]), 32'd2);
        check_eq("mid sop", 32'(reg_sop[0]), 32'd0);
        rst = 1'b1;
        #1;
        check_eq("mid rst tready", 32'(tready[0]), 32'd0);
        check_eq("mid rst valid", 32'(reg_tvalid[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("post rst count", 32'(fcount[0]), 32'd0);
        check_eq("post rst pkt", 32'(pcount[0]), 32'd0);
        check_eq("post rst valid", 32'(reg_tvalid[0]), 32'd0);
        @(negedge clk);
        stream(0, "post rst ct", 2, 71, 1);
        // Single-beat packet: sop and last together
        stream(1, "post rst pm1", 1, 61, 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/st_fifo_ml.md
Name: st_fifo_ml

Overview:
- Parametrised successor to the single-stage axis-like register slice.
- Buffers an axis-like stream (valid/last/user/data/ready) in a DEPTH-entry FIFO.
- Two modes: cut-through, or packet mode (store-and-forward with a deadlock escape).
- Exports occupancy, stored-packet count and a start-of-packet flag; used between PCIe TLP stages that need more than one cycle of elasticity.

Parameters:
- TUSER_WIDTH, 128, width of axis_tuser / axis_reg_tuser.
- TDATA_WIDTH, 256, width of axis_tdata / axis_reg_tdata.
- DEPTH, 4, number of entries; power of two, >= 2 (elaboration error otherwise).
- PKT_MODE, 0, 0 = cut-through, 1 = store-and-forward.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- axis_tvalid  in  1  input beat valid.
- axis_tlast  in  1  last beat of packet.
- axis_tuser  in  TUSER_WIDTH  per-beat sideband.
- axis_tdata  in  TDATA_WIDTH  payload.
- axis_tready  out  1  FIFO can accept a beat.
- axis_reg_tvalid  out  1  output beat valid.
- axis_reg_tlast  out  1  output last.
- axis_reg_tuser  out  TUSER_WIDTH  output sideband.
- axis_reg_tdata  out  TDATA_WIDTH  output payload.
- axis_reg_tready  in  1  downstream accepts.
- axis_reg_sop  out  1  current output beat is the first beat of a packet.
- fifo_count  out  $clog2(DEPTH)+1  entries stored.
- pkt_count  out  $clog2(DEPTH)+1  complete packets stored (entries with tlast).

Behaviour:
- Push = axis_tvalid & axis_tready; pop = axis_reg_tvalid & axis_reg_tready.
- Reset (rst high at posedge):
  - wr/rd pointers, fifo_count, pkt_count -> 0; sop flag -> 1.
  - Storage array is not reset.
  - While rst is high: axis_tready = 0 and axis_reg_tvalid = 0.
  - Reset mid-packet discards all contents; the first beat after reset is treated as SOP.
- axis_tready = !rst & (fifo_count != DEPTH). Registered state only; no combinational path from axis_reg_tready.
- Full condition:
  - A push is impossible while full.
  - A pop while full makes axis_tready 1 on the next cycle (no same-cycle pass-through).
- Latency: a beat pushed at edge N is presentable at the output from cycle N+1 (the head entry is read combinationally from the array).
- fifo_count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- pkt_count:
  - +1 on a push with tlast; -1 on a pop with tlast.
  - Unchanged when both occur in the same cycle.
  - Saturates neither way; by construction 0..DEPTH.
- Pointers: $clog2(DEPTH) bits, natural wrap at DEPTH.
- axis_reg_tvalid:
  - PKT_MODE=0: fifo_count != 0.
  - PKT_MODE=1: fifo_count != 0 & (pkt_count != 0 | fifo_count == DEPTH).
  - The full escape releases a packet longer than DEPTH in cut-through fashion. Once a beat of a packet has been released, the rest of that packet is also released as it arrives, until its tlast pops. Tracked by an escape flag: set on a pop while full with pkt_count == 0, cleared on a pop with tlast.
- Valid stability: once axis_reg_tvalid is asserted, it and the head beat's data hold until pop (AXI rule). Packet-mode gating only ever turns valid on; it never turns it off without a pop.
- axis_reg_sop: sop flag & axis_reg_tvalid. The flag is cleared on a pop without tlast and set on a pop with tlast.
- Output zeroing: when axis_reg_tvalid = 0, axis_reg_tlast, axis_reg_tuser and axis_reg_tdata are driven all-zero.
- Single-beat packet (tlast on the first beat): sop and last are both high on the same output beat.

Test Plan:
- Reset then idle, DEPTH=4 -> reg_tvalid=0, outputs all 0, fifo_count=0, tready=0 during rst and 1 on the first cycle after release.
- PKT_MODE=0, push 4 beats (data 1..4, last on 4) with reg_tready=0 -> tready=0 after 4th push, fifo_count=4, pkt_count=1. Then reg_tready=1 -> data 1,2,3,4 in order, sop only on beat 1, last only on beat 4.
- Simultaneous push/pop at count=2 for 10 cycles -> fifo_count stays 2, no beat lost or reordered, pointers wrap past index 3.
- PKT_MODE=1, push 3 beats without tlast, reg_tready=1 -> reg_tvalid stays 0. Push a 4th beat with tlast -> reg_tvalid=1 next cycle, 4 beats drain in order.
- PKT_MODE=1, DEPTH=4, 6-beat packet -> at count=4 with pkt_count=0, escape releases beat 1; beats 5,6 follow cut-through; all 6 delivered, sop on beat 1, last on beat 6.
- Assert rst mid-packet (2 beats stored) -> next cycle fifo_count=0, reg_tvalid=0. A new packet pushed afterwards shows sop on its first beat.
